// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default baud divider and data width.
package uart_pkg;

  localparam int unsigned BaudCountDefault = 10416;
  localparam int unsigned DataWidth        = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial line in, byte and status strobes out.
interface uart_rx_if import uart_pkg::*; ();

  logic                 rx;
  logic [DataWidth-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_err;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable reset value.
module uart_sync2 #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start validation, centre sampling of data and stop bits,
// one-cycle valid / framing-error strobes.
module uart_rx import uart_pkg::*; #(
  parameter int unsigned BAUD_COUNT = BaudCountDefault
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned HALF_COUNT = BAUD_COUNT / 2;
  localparam int unsigned CNT_W      = $clog2(BAUD_COUNT);
  localparam logic [CNT_W-1:0] BaudLast = CNT_W'(BAUD_COUNT - 1);
  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(HALF_COUNT - 1);

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Counter restarts from zero on every state change, so each state times from its own entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == BaudLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DataWidth-1:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (cnt_q == BaudLast) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        // Hold off until the line idles so a stuck-low line cannot spawn frames.
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_busy   = (state_q != StIdle);
  assign bus.frame_err = err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the existing uart_tx on the same 100 MHz clock domain at 9600 baud.
- Synchronises the asynchronous rx line and validates the start bit at mid-bit.
- Samples 8 data bits LSB first at bit centres and checks the stop bit.
- Presents each byte with a one-cycle valid strobe, or flags a framing error.

Parameters:
- BAUD_COUNT, 10416: clk cycles per bit (100 MHz / 9600). Legal range 4 and up.
- HALF_COUNT, BAUD_COUNT/2 (localparam, integer divide): cycles from start-bit edge to its centre.
- CNT_W, $clog2(BAUD_COUNT) (localparam): baud counter width. Equals 14 at the default.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronous to clk externally.
- rx  in  1  serial input line, asynchronous, idle high.
- rx_data  out  8  last correctly framed byte. Holds its value until the next good frame.
- rx_valid  out  1  one-clk pulse; rx_data is new this cycle.
- rx_busy  out  1  high from start-bit acceptance until return to IDLE.
- frame_err  out  1  one-clk pulse when the stop bit samples low.

Behaviour:
- Reset (rst=0, any state, including mid-frame):
  - state=IDLE, counters 0, shift register 0, synchroniser flops 1.
  - rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0.
  - A frame in progress is discarded, with no pulse.
- Input: rx passes through a 2-flop synchroniser (reset value 1). rx_s is the second flop. All decisions use rx_s only, so there is 2 clk of input latency.
- Baud counter: counts 0..limit-1 and clears to 0 on every state transition.
- State machine:
  - IDLE: rx_busy=0. When rx_s==0, go to START and set rx_busy=1 on the next cycle.
  - START: at count HALF_COUNT-1, sample rx_s.
    - If rx_s==0, go to DATA with bit_cnt=0.
    - If rx_s==1, treat it as a glitch: go to IDLE with no pulse and rx_busy=0.
  - DATA: at count BAUD_COUNT-1 (the bit centre), do shift = {rx_s, shift[7:1]}.
    - bit_cnt increments 0..7.
    - After the sample taken when bit_cnt==7, go to STOP.
  - STOP: at count BAUD_COUNT-1, sample rx_s.
    - If rx_s==1: load rx_data from the shift register, pulse rx_valid for 1 cycle, go to IDLE.
    - If rx_s==0: pulse frame_err for 1 cycle, leave rx_data unchanged, go to BREAK.
  - BREAK: rx_busy stays 1. Wait until rx_s==1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Return timing: the FSM returns to IDLE at the stop-bit centre, leaving half a bit of margin for back-to-back frames. A new start edge in the second half of the stop bit is accepted.
- Output exclusivity: rx_valid and frame_err are never high together. Each is high for exactly one clk per frame.
- No output handshake: a consumer that misses the rx_valid pulse loses the byte. There is no overrun flag.
- Latency: rx_valid asserts 2 + HALF_COUNT + 9·BAUD_COUNT + 2 clk (±1) after the rx falling edge. The bench checks this to ±2 clk.
- Encoding: unknown or illegal state encodings go to IDLE.

Decomposition:
- Shared package uart_pkg:
  - state localparams IDLE, START, DATA, STOP, BREAK (3-bit encoding);
  - default BAUD_COUNT=10416;
  - data width 8.
- uart_tx can migrate to the package later.
- One sub-module: uart_sync2, a 2-flop synchroniser with reset value parameter RST_VAL=1, clk and rst ports. It is reused for any future async inputs.

Test Plan:
- Use BAUD_COUNT=16 for all scenarios.
- Reset: hold rst=0 for 5 clk with rx toggling -> all outputs 0 and rx_busy=0. Release -> outputs stay 0 with rx=1.
- Good byte: drive 8'hA5 LSB first (bit pattern 1,0,1,0,0,1,0,1) with stop=1 -> exactly one rx_valid pulse, rx_data=8'hA5, frame_err never high. Pulse lands 2+8+144+2 clk (±2) after the start edge.
- Back-to-back: send 8'h00 then 8'hFF with no idle gap -> two rx_valid pulses, 160±2 clk apart, carrying 8'h00 then 8'hFF.
- Framing error: send 8'h3C with stop=0, then hold rx low for 40 clk, then release high -> one frame_err pulse, no rx_valid, rx_data keeps its previous value, and no further frame starts until rx returns high.
- Glitch: pulse rx low for 3 clk only -> the FSM enters START, returns to IDLE at the half-bit check, and no rx_valid or frame_err occurs.
- Reset mid-frame: assert rst=0 during bit 4 of 8'h5A, release, then send 8'h81 -> no pulse for the aborted frame, then rx_valid with rx_data=8'h81.
